// File: rtl/regmap_master_if.sv
// regmap_master_if: request/response channels plus regmap bus for regmap_master.
// Ports: req (valid/ready/write/addr/wdata), rsp (valid/ready/rdata/err), regmap (wren/addr/wrdata/rdvalid/rddata).
interface regmap_master_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic                  i_req_write;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic [DATA_WIDTH-1:0] i_req_wdata;
  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [DATA_WIDTH-1:0] o_rsp_rdata;
  logic                  o_rsp_err;
  logic                  o_wren;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic [DATA_WIDTH-1:0] o_wrdata;
  logic                  i_rdvalid;
  logic [DATA_WIDTH-1:0] i_rddata;

  modport master (
    input  i_req_valid, i_req_write, i_req_addr, i_req_wdata,
    input  i_rsp_ready, i_rdvalid, i_rddata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    output o_wren, o_addr, o_wrdata
  );

  modport slave (
    output i_req_valid, i_req_write, i_req_addr, i_req_wdata,
    output i_rsp_ready, i_rdvalid, i_rddata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    input  o_wren, o_addr, o_wrdata
  );
endinterface

// File: rtl/regmap_master.sv
// regmap_master: single-outstanding register access initiator for regmap.
// Ports: i_clk, i_rst (async active-high), bus (regmap_master_if.master), o_busy.
// Option: REGMAP_MASTER_WRVERIFY_EN adds a readback-and-compare after each write.
module regmap_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int TIMEOUT    = 15
) (
  input  logic            i_clk,
  input  logic            i_rst,
  regmap_master_if.master bus,
  output logic            o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ_WAIT,
    RESP
  } state_t;

  localparam logic [8:0] LAT = 9'(RD_LATENCY);
  localparam logic [8:0] LIM = 9'(RD_LATENCY + TIMEOUT);

  state_t                state_q, state_d;
  logic [8:0]            cnt_q, cnt_d;
  logic                  wren_q, wren_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wrdata_q, wrdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  req_ready;
`ifdef REGMAP_MASTER_WRVERIFY_EN
  logic                  vfy_q, vfy_d;
`endif

  assign req_ready       = (state_q == IDLE) && !i_rst;
  assign bus.o_req_ready = req_ready;
  assign bus.o_wren      = wren_q;
  assign bus.o_addr      = addr_q;
  assign bus.o_wrdata    = wrdata_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_rdata = rdata_q;
  assign bus.o_rsp_err   = err_q;
  assign o_busy          = busy_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wren_d      = 1'b0;
    addr_d      = addr_q;
    wrdata_d    = wrdata_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
`ifdef REGMAP_MASTER_WRVERIFY_EN
    vfy_d       = vfy_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.i_req_valid && req_ready) begin
          addr_d   = bus.i_req_addr;
          wrdata_d = bus.i_req_wdata;
          cnt_d    = '0;
`ifdef REGMAP_MASTER_WRVERIFY_EN
          vfy_d    = bus.i_req_write;
`endif
          if (bus.i_req_write) begin
            state_d = WRITE;
            wren_d  = 1'b1;
          end else begin
            state_d = READ_WAIT;
          end
        end
      end
      WRITE: begin
`ifdef REGMAP_MASTER_WRVERIFY_EN
        state_d = READ_WAIT;
        cnt_d   = '0;
`else
        state_d     = RESP;
        rdata_d     = '0;
        err_d       = 1'b0;
        rsp_valid_d = 1'b1;
`endif
      end
      READ_WAIT: begin
        cnt_d = cnt_q + 9'd1;
        if (cnt_q >= LAT && bus.i_rdvalid) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rdata_d     = bus.i_rddata;
`ifdef REGMAP_MASTER_WRVERIFY_EN
          err_d       = vfy_q && (bus.i_rddata != wrdata_q);
`else
          err_d       = 1'b0;
`endif
        end else if (cnt_q >= LIM) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rdata_d     = '0;
          err_d       = 1'b1;
        end
      end
      RESP: begin
        if (bus.i_rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wren_q      <= 1'b0;
      addr_q      <= '0;
      wrdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wren_q      <= wren_d;
      addr_q      <= addr_d;
      wrdata_q    <= wrdata_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

`ifdef REGMAP_MASTER_WRVERIFY_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) vfy_q <= 1'b0;
    else       vfy_q <= vfy_d;
  end
`endif

endmodule
